ikaopll_lfo_apply: RTL and testbench

Consumer side of the LFO value pair on the OPLL slot bus. Latches the vibrato step (PMVAL) and tremolo step (AMVAL) once per 18-slot frame. Applies them per slot:
- vibrato offsets the slot's F-number, which is then block-shifted into a phase increment;
- tremolo gates the AM attenuation.

Sits between the LFO and the phase/envelope generators. Time-multiplexed, one slot per phi1 negative-edge enable.

---
 rtl/ikaopll_lfo_apply.sv | 150 +++++++++++++++
 tb/tb_ikaopll_lfo_apply.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ikaopll_lfo_apply.sv
// ikaopll_lfo_apply
// Consumer side of the LFO value pair on the OPLL slot bus. The vibrato step
// (PMVAL) and tremolo step (AMVAL) are captured once per 18-slot frame. They
// are then applied to each time-multiplexed slot:
//   - vibrato offsets the doubled F-number, which is then block-shifted into a
//     phase increment;
//   - tremolo gates the AM attenuation.
// The datapath is a two-stage pipeline. It advances only on enable cycles,
// which are EMUCLK posedges with i_phi1_NCEN_n low.
//
// Ports
//   i_EMUCLK       emulator master clock, all state on posedge
//   i_IC_n         asynchronous active-low reset
//   i_phi1_NCEN_n  active-low clock enable
//   i_CYCLE_00     marks the slot-0 enable cycle of each frame
//   i_PMVAL        vibrato step from LFO (3 bits)
//   i_AMVAL        tremolo step from LFO (4 bits)
//   i_FNUM         F-number of the presented slot (9 bits)
//   i_BLOCK        octave block of the presented slot (3 bits)
//   i_PM_EN        vibrato enable of the presented slot
//   i_AM_EN        tremolo enable of the presented slot
//   o_SLOT         slot index tagged to the outputs (0..17)
//   o_FNUM_PM      vibrato-modified doubled F-number (10 bits)
//   o_PHASEINC     phase increment (16 bits)
//   o_AMATT        tremolo attenuation (4 bits)

module ikaopll_lfo_apply (
    input  logic        i_EMUCLK,
    input  logic        i_IC_n,
    input  logic        i_phi1_NCEN_n,
    input  logic        i_CYCLE_00,
    input  logic [2:0]  i_PMVAL,
    input  logic [3:0]  i_AMVAL,
    input  logic [8:0]  i_FNUM,
    input  logic [2:0]  i_BLOCK,
    input  logic        i_PM_EN,
    input  logic        i_AM_EN,
    output logic [4:0]  o_SLOT,
    output logic [9:0]  o_FNUM_PM,
    output logic [15:0] o_PHASEINC,
    output logic [3:0]  o_AMATT
);

    logic        en;

    logic [4:0]  slot_cnt;
    logic        slot_run;
    logic [2:0]  pm_h;
    logic [3:0]  am_h;

    logic [4:0]  slot_in;
    logic [2:0]  pm;
    logic [3:0]  am;
    logic [2:0]  delta;
    logic [10:0] fnum_sum;
    logic [3:0]  am_res;

    logic [4:0]  s1_slot;
    logic [9:0]  s1_fnum;
    logic [2:0]  s1_block;
    logic [3:0]  s1_am;

    logic [16:0] shift_wide;

    assign en = ~i_phi1_NCEN_n;

    // slot_run is clear straight after reset. This makes the first enable
    // cycle count as slot 0, even when reset is released mid-frame.
    always_comb begin
        slot_in = 5'd0;
        if (!i_CYCLE_00 && slot_run && (slot_cnt != 5'd17)) begin
            slot_in = slot_cnt + 5'd1;
        end
    end

    // The slot-0 cycle uses the live LFO values. This keeps the whole frame
    // on the same pair that the hold registers capture at that moment.
    assign pm = i_CYCLE_00 ? i_PMVAL : pm_h;
    assign am = i_CYCLE_00 ? i_AMVAL : am_h;

    // The vibrato magnitude is either fnum>>6 (full step) or fnum>>7
    // (half step). pm[2] selects subtraction. Because delta <= fnum>>6, the
    // subtraction can never underflow, but the addition may wrap at 1024.
    always_comb begin
        delta = 3'd0;
        if (i_PM_EN) begin
            if (pm[0]) begin
                delta = {1'b0, i_FNUM[8:7]};
            end else if (pm[1]) begin
                delta = i_FNUM[8:6];
            end
        end
        if (pm[2]) begin
            fnum_sum = {1'b0, i_FNUM, 1'b0} - {8'd0, delta};
        end else begin
            fnum_sum = {1'b0, i_FNUM, 1'b0} + {8'd0, delta};
        end
    end

    assign am_res = i_AM_EN ? am : 4'd0;

    // The shift is 17 bits wide, so 1023 << 7 keeps its top bit before the
    // final halving.
    assign shift_wide = {7'd0, s1_fnum} << s1_block;

    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            slot_cnt <= 5'd0;
            slot_run <= 1'b0;
            pm_h     <= 3'd0;
            am_h     <= 4'd0;
        end else if (en) begin
            slot_cnt <= slot_in;
            slot_run <= 1'b1;
            if (i_CYCLE_00) begin
                pm_h <= i_PMVAL;
                am_h <= i_AMVAL;
            end
        end
    end

    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            s1_slot  <= 5'd0;
            s1_fnum  <= 10'd0;
            s1_block <= 3'd0;
            s1_am    <= 4'd0;
        end else if (en) begin
            s1_slot  <= slot_in;
            s1_fnum  <= fnum_sum[9:0];
            s1_block <= i_BLOCK;
            s1_am    <= am_res;
        end
    end

    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            o_SLOT     <= 5'd0;
            o_FNUM_PM  <= 10'd0;
            o_PHASEINC <= 16'd0;
            o_AMATT    <= 4'd0;
        end else if (en) begin
            o_SLOT     <= s1_slot;
            o_FNUM_PM  <= s1_fnum;
            o_PHASEINC <= shift_wide[16:1];
            o_AMATT    <= s1_am;
        end
    end

endmodule

// File: tb/tb_ikaopll_lfo_apply.sv
// tb_ikaopll_lfo_apply
// Directed testbench for ikaopll_lfo_apply. Each scenario task drives enable
// cycles and checks the outputs one enable later, which is when the
// two-stage pipeline presents the result for the operand driven earlier.

module tb_ikaopll_lfo_apply;

    logic        clk;
    logic        rst_n;
    logic        ncen;
    logic        cyc00;
    logic [2:0]  pmval;
    logic [3:0]  amval;
    logic [8:0]  fnum;
    logic [2:0]  block;
    logic        pm_en;
    logic        am_en;
    logic [4:0]  slot;
    logic [9:0]  fnum_pm;
    logic [15:0] phaseinc;
    logic [3:0]  amatt;

    int vectors;
    int miscompares;

    ikaopll_lfo_apply dut (
        .i_EMUCLK      (clk),
        .i_IC_n        (rst_n),
        .i_phi1_NCEN_n (ncen),
        .i_CYCLE_00    (cyc00),
        .i_PMVAL       (pmval),
        .i_AMVAL       (amval),
        .i_FNUM        (fnum),
        .i_BLOCK       (block),
        .i_PM_EN       (pm_en),
        .i_AM_EN       (am_en),
        .o_SLOT        (slot),
        .o_FNUM_PM     (fnum_pm),
        .o_PHASEINC    (phaseinc),
        .o_AMATT       (amatt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one enable cycle and samples 1 time unit after the edge.
    task automatic tick(input logic c0, input logic [2:0] pmv, input logic [3:0] amv,
                        input logic [8:0] fn, input logic [2:0] blk,
                        input logic pe, input logic ae);
        cyc00 = c0;
        pmval = pmv;
        amval = amv;
        fnum  = fn;
        block = blk;
        pm_en = pe;
        am_en = ae;
        ncen  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Drives non-enable cycles with scrambled inputs.
    task automatic gap(input int n);
        ncen  = 1'b1;
        cyc00 = 1'($urandom);
        pmval = 3'($urandom);
        amval = 4'($urandom);
        fnum  = 9'($urandom);
        block = 3'($urandom);
        pm_en = 1'($urandom);
        am_en = 1'($urandom);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ncen  = 1'b0;
        cyc00 = 1'b0;
        pmval = 3'd7;
        amval = 4'hF;
        fnum  = 9'd511;
        block = 3'd7;
        pm_en = 1'b1;
        am_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (slot !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_slot: got %0d, want 0", slot);
        end
        vectors++;
        if (fnum_pm !== 10'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_fnum_pm: got %0d, want 0", fnum_pm);
        end
        vectors++;
        if (phaseinc !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_phaseinc: got %0d, want 0", phaseinc);
        end
        vectors++;
        if (amatt !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_amatt: got %0d, want 0", amatt);
        end
        ncen = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if ({slot, fnum_pm, phaseinc, amatt} !== 35'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got slot=%0d fnum_pm=%0d phaseinc=%0d amatt=%0d, want all 0",
                     slot, fnum_pm, phaseinc, amatt);
        end
    endtask

    task automatic test_vibrato();
        int vib_exp[8] = '{896, 899, 903, 899, 896, 893, 889, 893};
        for (int p = 0; p < 8; p++) begin
            for (int j = 0; j < 18; j++) begin
                tick(j == 0, 3'(p), 4'd0, 9'h1C0, 3'd4, 1'b1, 1'b0);
                if (j >= 1) begin
                    vectors++;
                    if (slot !== 5'(j - 1)) begin
                        miscompares++;
                        $display("[TB] FAIL vib_slot p=%0d: got %0d, want %0d", p, slot, j - 1);
                    end
                    vectors++;
                    if (fnum_pm !== 10'(vib_exp[p])) begin
                        miscompares++;
                        $display("[TB] FAIL vib_fnum_pm p=%0d slot=%0d: got %0d, want %0d",
                                 p, j - 1, fnum_pm, vib_exp[p]);
                    end
                    vectors++;
                    if (phaseinc !== 16'(vib_exp[p] * 8)) begin
                        miscompares++;
                        $display("[TB] FAIL vib_phaseinc p=%0d slot=%0d: got %0d, want %0d",
                                 p, j - 1, phaseinc, vib_exp[p] * 8);
                    end
                end
            end
        end
    endtask

    task automatic test_frame_latch();
        logic [2:0] pmv;
        int         op;
        int         want;
        for (int t = 0; t < 37; t++) begin
            pmv = (t < 5) ? 3'd2 : 3'd6;
            tick((t == 0) || (t == 18) || (t == 36), pmv, 4'd0, 9'h1C0, 3'd4, 1'b1, 1'b0);
            if (t >= 1) begin
                op   = t - 1;
                want = (op < 18) ? 903 : 889;
                vectors++;
                if (slot !== 5'(op % 18)) begin
                    miscompares++;
                    $display("[TB] FAIL latch_slot op=%0d: got %0d, want %0d", op, slot, op % 18);
                end
                vectors++;
                if (fnum_pm !== 10'(want)) begin
                    miscompares++;
                    $display("[TB] FAIL latch_fnum_pm op=%0d: got %0d, want %0d", op, fnum_pm, want);
                end
            end
        end
    endtask

    task automatic test_tremolo();
        logic c0;
        int   op;
        for (int t = 0; t < 20; t++) begin
            c0 = (t == 0) || (t == 18);
            tick(c0, 3'd2, c0 ? 4'hD : 4'h3, 9'd300, 3'd1, 1'b0, (t % 2) == 0);
            if (t >= 1) begin
                op = t - 1;
                vectors++;
                if (slot !== 5'(op % 18)) begin
                    miscompares++;
                    $display("[TB] FAIL trem_slot op=%0d: got %0d, want %0d", op, slot, op % 18);
                end
                vectors++;
                if (amatt !== (((op % 2) == 0) ? 4'hD : 4'h0)) begin
                    miscompares++;
                    $display("[TB] FAIL trem_amatt op=%0d: got %0h, want %0h",
                             op, amatt, ((op % 2) == 0) ? 4'hD : 4'h0);
                end
                vectors++;
                if (fnum_pm !== 10'd600) begin
                    miscompares++;
                    $display("[TB] FAIL trem_fnum_pm op=%0d: got %0d, want 600", op, fnum_pm);
                end
            end
        end
    endtask

    task automatic test_boundaries();
        tick(1'b1, 3'd2, 4'd0, 9'd511, 3'd7, 1'b1, 1'b0);
        tick(1'b1, 3'd0, 4'd0, 9'd511, 3'd7, 1'b1, 1'b0);
        vectors++;
        if (fnum_pm !== 10'd5) begin
            miscompares++;
            $display("[TB] FAIL wrap_fnum_pm: got %0d, want 5", fnum_pm);
        end
        vectors++;
        if (phaseinc !== 16'd320) begin
            miscompares++;
            $display("[TB] FAIL wrap_phaseinc: got %0d, want 320", phaseinc);
        end
        tick(1'b0, 3'd0, 4'd0, 9'd0, 3'd0, 1'b0, 1'b0);
        vectors++;
        if (fnum_pm !== 10'd1022) begin
            miscompares++;
            $display("[TB] FAIL max_fnum_pm: got %0d, want 1022", fnum_pm);
        end
        vectors++;
        if (phaseinc !== 16'd65408) begin
            miscompares++;
            $display("[TB] FAIL max_phaseinc: got %0d, want 65408", phaseinc);
        end
        vectors++;
        if (slot !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL resync_slot: got %0d, want 0", slot);
        end
    endtask

    task automatic test_async_reset_gaps();
        for (int j = 0; j < 10; j++) begin
            tick(j == 0, 3'd2, 4'h9, 9'd200, 3'd3, 1'b1, 1'b1);
        end
        vectors++;
        if (slot !== 5'd8) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_slot: got %0d, want 8", slot);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({slot, fnum_pm, phaseinc, amatt} !== 35'd0) begin
            miscompares++;
            $display("[TB] FAIL async_clear: got slot=%0d fnum_pm=%0d phaseinc=%0d amatt=%0d, want all 0",
                     slot, fnum_pm, phaseinc, amatt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // A: slot 0 after reset; the cleared hold register gives am 0.
        tick(1'b0, 3'd7, 4'hF, 9'd100, 3'd2, 1'b0, 1'b1);
        gap(3);
        vectors++;
        if ({slot, fnum_pm, phaseinc, amatt} !== 35'd0) begin
            miscompares++;
            $display("[TB] FAIL gap_hold_a: got slot=%0d fnum_pm=%0d phaseinc=%0d amatt=%0d, want all 0",
                     slot, fnum_pm, phaseinc, amatt);
        end
        // B: slot 1; outputs now show A.
        tick(1'b0, 3'd7, 4'hF, 9'd50, 3'd0, 1'b0, 1'b1);
        vectors++;
        if ((slot !== 5'd0) || (fnum_pm !== 10'd200) || (phaseinc !== 16'd400) || (amatt !== 4'd0)) begin
            miscompares++;
            $display("[TB] FAIL post_reset_a: got slot=%0d fnum_pm=%0d phaseinc=%0d amatt=%0d, want 0/200/400/0",
                     slot, fnum_pm, phaseinc, amatt);
        end
        gap(5);
        vectors++;
        if ((slot !== 5'd0) || (fnum_pm !== 10'd200) || (phaseinc !== 16'd400) || (amatt !== 4'd0)) begin
            miscompares++;
            $display("[TB] FAIL gap_hold_b: got slot=%0d fnum_pm=%0d phaseinc=%0d amatt=%0d, want 0/200/400/0",
                     slot, fnum_pm, phaseinc, amatt);
        end
        // C: frame start that resynchronises the counter and loads am 0xA.
        tick(1'b1, 3'd0, 4'hA, 9'd10, 3'd1, 1'b0, 1'b1);
        vectors++;
        if ((slot !== 5'd1) || (fnum_pm !== 10'd100) || (phaseinc !== 16'd50) || (amatt !== 4'd0)) begin
            miscompares++;
            $display("[TB] FAIL post_reset_b: got slot=%0d fnum_pm=%0d phaseinc=%0d amatt=%0d, want 1/100/50/0",
                     slot, fnum_pm, phaseinc, amatt);
        end
        // D: slot 1 of the new frame, using the held am.
        tick(1'b0, 3'd0, 4'h2, 9'd10, 3'd1, 1'b0, 1'b1);
        vectors++;
        if ((slot !== 5'd0) || (fnum_pm !== 10'd20) || (phaseinc !== 16'd20) || (amatt !== 4'hA)) begin
            miscompares++;
            $display("[TB] FAIL resync_c: got slot=%0d fnum_pm=%0d phaseinc=%0d amatt=%0d, want 0/20/20/10",
                     slot, fnum_pm, phaseinc, amatt);
        end
        gap(2);
        tick(1'b0, 3'd0, 4'h2, 9'd10, 3'd1, 1'b0, 1'b1);
        vectors++;
        if ((slot !== 5'd1) || (amatt !== 4'hA)) begin
            miscompares++;
            $display("[TB] FAIL resync_d: got slot=%0d amatt=%0d, want 1/10", slot, amatt);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_vibrato();
        test_frame_latch();
        test_tremolo();
        test_boundaries();
        test_async_reset_gaps();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
